// File: rtl/riscv_pkg.sv
// Shared RV32I pipeline definitions: datapath width, bubble encoding and the
// IF/ID register payload consumed by the decode stage.
package riscv_pkg;

  localparam int unsigned     XLEN      = 32;
  localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013;
  localparam logic [XLEN-1:0] RESET_PC  = 32'h0000_0000;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] pc_plus4;
    logic [XLEN-1:0] instr;
    logic            valid;
  } if_id_t;

  function automatic if_id_t if_id_bubble(input logic [XLEN-1:0] nop);
    if_id_t b;
    b.pc       = '0;
    b.pc_plus4 = '0;
    b.instr    = nop;
    b.valid    = 1'b0;
    return b;
  endfunction

endpackage

// File: rtl/if_stage_if.sv
// Instruction-memory read port: the fetch stage drives the byte address and
// the combinational memory returns the instruction word in the same cycle.
interface if_stage_if;

  logic [riscv_pkg::XLEN-1:0] addr;
  logic [riscv_pkg::XLEN-1:0] instr;

  modport master (output addr, input instr);
  modport slave  (input addr, output instr);

endinterface

// File: rtl/if_id_reg.sv
// Async-reset pipeline register with hold and flush; flush wins over load and
// both the reset and flush values are the bubble given by RST_VAL.
module if_id_reg
  import riscv_pkg::*;
#(
  parameter if_id_t RST_VAL = if_id_bubble(NOP_INSTR)
) (
  input  logic   clk,
  input  logic   rst,
  input  logic   load_i,
  input  logic   flush_i,
  input  if_id_t d_i,
  output if_id_t q_o
);

  if_id_t data_d, data_q;

  // NOTE: data_d defaults to data_q before any branch, so no path leaves it
  // unassigned and no latch is inferred.
  always_comb begin
    data_d = data_q;
    if (flush_i) begin
      data_d = RST_VAL;
    end else if (load_i) begin
      data_d = d_i;
    end
  end

  // NOTE: state is updated with <= so every flop samples the pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data_q <= RST_VAL;
    end else begin
      data_q <= data_d;
    end
  end

  assign q_o = data_q;

endmodule

// File: rtl/if_stage.sv
// RV32I instruction-fetch stage: PC register, next-PC selection
// (redirect > stall > advance), IF/ID register and valid-fetch counter.
module if_stage #(
  parameter int unsigned     XLEN      = riscv_pkg::XLEN,
  parameter logic [XLEN-1:0] RESET_PC  = riscv_pkg::RESET_PC,
  parameter logic [XLEN-1:0] NOP_INSTR = riscv_pkg::NOP_INSTR
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            stall_i,
  input  logic            redirect_i,
  input  logic [XLEN-1:0] redirect_pc_i,
  if_stage_if.master      imem,
  output logic [XLEN-1:0] if_id_pc_o,
  output logic [XLEN-1:0] if_id_pc_plus4_o,
  output logic [XLEN-1:0] if_id_instr_o,
  output logic            if_id_valid_o,
  output logic [31:0]     fetch_count_o
);

  localparam logic [XLEN-1:0] ALIGN_MASK = ~XLEN'(3);
  localparam riscv_pkg::if_id_t BUBBLE = riscv_pkg::if_id_bubble(NOP_INSTR);

  logic [XLEN-1:0]   pc_d, pc_q, pc_plus4;
  logic [31:0]       fetch_count_d, fetch_count_q;
  logic              if_id_load, if_id_flush;
  riscv_pkg::if_id_t fetch_data, if_id_q;

  assign pc_plus4  = pc_q + XLEN'(4);
  assign imem.addr = pc_q;

  always_comb begin
    fetch_data.pc       = pc_q;
    fetch_data.pc_plus4 = pc_plus4;
    fetch_data.instr    = imem.instr;
    fetch_data.valid    = 1'b1;
  end

  // A redirect squashes the fetch in flight even when decode asks to stall.
  always_comb begin
    pc_d          = pc_q;
    fetch_count_d = fetch_count_q;
    if_id_load    = 1'b0;
    if_id_flush   = 1'b0;
    if (redirect_i) begin
      pc_d        = redirect_pc_i & ALIGN_MASK;
      if_id_flush = 1'b1;
    end else if (!stall_i) begin
      pc_d          = pc_plus4;
      fetch_count_d = fetch_count_q + 32'd1;
      if_id_load    = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_q          <= RESET_PC & ALIGN_MASK;
      fetch_count_q <= '0;
    end else begin
      pc_q          <= pc_d;
      fetch_count_q <= fetch_count_d;
    end
  end

  if_id_reg #(
    .RST_VAL (BUBBLE)
  ) u_if_id_reg (
    .clk     (clk),
    .rst     (rst),
    .load_i  (if_id_load),
    .flush_i (if_id_flush),
    .d_i     (fetch_data),
    .q_o     (if_id_q)
  );

  assign if_id_pc_o       = if_id_q.pc;
  assign if_id_pc_plus4_o = if_id_q.pc_plus4;
  assign if_id_instr_o    = if_id_q.instr;
  assign if_id_valid_o    = if_id_q.valid;
  assign fetch_count_o    = fetch_count_q;

endmodule
